memoria_controle: RTL and testbench
===================================

Name: memoria_controle

Overview:
- Multicycle sequencer for the memory subsystem (instruction memory + IR, data memory) of the RV64 core.
- Generates the IR load strobe `atualiza_pc`, the data-memory write enable `WeDM`, the register-file write enable and the PC advance pulse.
- Decodes the opcode of the instruction held in IR and steps each instruction through fetch/decode/execute/memory/writeback.
- Holds the memory state for a configurable data-memory latency.

Parameters:
- LAT_DM, 1, cycles the MEM state is held for load/store (legal range 1..15).
- W_CONT, 32, width of the optional retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- habilita  input  1  run enable; sampled only in FETCH.
- doutIR  input  32  current instruction from IR; only bits [6:0] (opcode) are used.
- atualiza_pc  output  1  IR load strobe (drives the IR clock); registered.
- WeDM  output  1  data-memory write enable; registered.
- WeRF  output  1  register-file write enable; registered.
- avanca_pc  output  1  one-cycle pulse: PC takes its next value.
- estado  output  3  current FSM state encoding, for debug.
- erro  output  1  sticky illegal-opcode flag.
- instret  output  W_CONT  retired count; present only with the optional feature.

Behaviour:
- Reset, synchronous on the clk edge while rst=1:
  - state goes to FETCH and the latency counter clears.
  - atualiza_pc, WeDM, WeRF, avanca_pc, erro and instret all go to 0.
  - rst overrides every other input, including in the middle of MEM; a pending store is dropped.
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- All outputs are Moore outputs, registered from the next state, so they are glitch-free. This matters because `atualiza_pc` is used as a clock.
- FETCH:
  - If habilita=1, go to DECODE and assert atualiza_pc for exactly one clk period.
  - If habilita=0, stay in FETCH with every strobe at 0.
- DECODE: doutIR is valid here. Classify the opcode:
  - 0110011 (R-type), 0010011 (I-ALU), 0000011 (load), 0100011 (store): go to EXEC.
  - 1100011 (branch): go to EXEC.
  - Any other opcode: go to TRAP.
- EXEC:
  - load or store: go to MEM and load the counter with LAT_DM-1.
  - R-type or I-ALU: go to WB.
  - branch: go to FETCH and pulse avanca_pc.
- MEM: stay while counter≠0, decrementing each cycle. On counter=0:
  - store: assert WeDM for exactly this one cycle (the last MEM cycle), then go to FETCH and pulse avanca_pc.
  - load: go to WB.
- WB: assert WeRF for one cycle, then go to FETCH and pulse avanca_pc.
- TRAP:
  - erro=1 and all strobes 0.
  - Stays in TRAP until rst; habilita is ignored.
- Instruction latency (cycles from the FETCH edge until FETCH is re-entered):
  - ALU: 4.
  - branch: 3.
  - store: 3+LAT_DM.
  - load: 4+LAT_DM.
- Exclusivity invariants:
  - WeDM and WeRF are never high in the same cycle.
  - atualiza_pc and avanca_pc are never high in the same cycle.
  - At most one WeDM pulse per instruction.
- Counter width is 4 bits; the counter never wraps, because it is loaded only from EXEC and never decremented below 0.

Optional Feature:
- Macro: MEMORIA_CONTROLE_INSTRET_EN.
- Defined:
  - The `instret` port exists.
  - It increments by 1 on every avanca_pc pulse and wraps modulo 2^W_CONT.
  - It clears on rst; TRAP does not count.
- Undefined: the port and the counter logic are absent. All other behaviour is identical.

Decomposition:
- Shared package `riscv_pkg`:
  - opcode constants: OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH.
  - state enum estado_t with the 3-bit encodings above.
  - instruction class enum.
- Sub-module `decodifica_opcode`: combinational, takes opcode[6:0] and returns the class plus an illegal flag. Reused later by the main control unit.

Test Plan:
- rst=1 for 2 cycles, then habilita=1 with doutIR=0x002081B3 (add):
  - estado 0→1→2→4→0.
  - atualiza_pc high in the first cycle; WeRF high in the WB cycle only; avanca_pc pulses once; total 4 cycles; WeDM never high.
- LAT_DM=3, doutIR=0x00113423 (sd):
  - MEM held 3 cycles; WeDM high only in the third.
  - No WeRF; FETCH re-entered after 6 cycles.
- LAT_DM=1, doutIR=0x0000B183 (ld):
  - estado 0,1,2,3,4; WeRF in WB; 5 cycles.
- doutIR=0xFFFFFFFF:
  - TRAP entered after DECODE; erro=1 and stuck for 20 cycles with habilita=1.
  - rst clears erro and returns to FETCH.
- LAT_DM=4, store, assert rst in the second MEM cycle:
  - Next edge: estado=0 and all outputs 0; WeDM is never asserted.
- With MEMORIA_CONTROLE_INSTRET_EN, W_CONT=4:
  - After 17 back-to-back add instructions, instret=1 (wrap).
  - habilita=0 holds FETCH with the count frozen.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the RV64 control path.
// Contents: major opcode constants, the multicycle state encoding (estado_t)
// and the coarse instruction class produced by decodifica_opcode.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Encodings are visible on the estado debug port and must stay fixed.
  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd7
  } estado_t;

  typedef enum logic [2:0] {
    ClsAlu,
    ClsLoad,
    ClsStore,
    ClsBranch,
    ClsIlegal
  } classe_t;

endpackage

// File: rtl/decodifica_opcode.sv
// Combinational opcode classifier.
// Ports:
//   opcode_i  - instruction bits [6:0]
//   classe_o  - instruction class (ALU, load, store, branch, illegal)
//   ilegal_o  - high when the opcode is not supported
module decodifica_opcode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode_i,
  output classe_t    classe_o,
  output logic       ilegal_o
);

  always_comb begin
    classe_o = ClsIlegal;
    ilegal_o = 1'b0;
    case (opcode_i)
      OP_R, OP_I: classe_o = ClsAlu;
      OP_LOAD:    classe_o = ClsLoad;
      OP_STORE:   classe_o = ClsStore;
      OP_BRANCH:  classe_o = ClsBranch;
      default:    ilegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/memoria_controle.sv
// Multicycle sequencer for instruction memory/IR and data memory.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB; illegal opcodes
// park the FSM in TRAP until reset.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   habilita     - run enable, sampled only in FETCH
//   doutIR       - instruction held in IR (only [6:0] used)
//   atualiza_pc  - IR load strobe (used as a clock, hence registered)
//   WeDM, WeRF   - data-memory / register-file write enables
//   avanca_pc    - one-cycle PC advance pulse
//   estado       - current state encoding (debug)
//   erro         - sticky illegal-opcode flag
//   instret      - retired-instruction count, only with
//                  MEMORIA_CONTROLE_INSTRET_EN defined
// Parameters: LAT_DM (1..15) MEM cycles for load/store, W_CONT width of instret.
module memoria_controle
  import riscv_pkg::*;
#(
  parameter int unsigned LAT_DM = 1,
  parameter int unsigned W_CONT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              habilita,
  input  logic [31:0]       doutIR,
  output logic              atualiza_pc,
  output logic              WeDM,
  output logic              WeRF,
  output logic              avanca_pc,
  output logic [2:0]        estado,
  output logic              erro
`ifdef MEMORIA_CONTROLE_INSTRET_EN
  ,
  output logic [W_CONT-1:0] instret
`endif
);

  localparam logic [3:0] CntCarga = 4'(LAT_DM - 1);

  estado_t    state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  classe_t    classe_q, classe_d;
  classe_t    classe_dec;
  logic       ilegal_dec;

  logic atualiza_q, atualiza_d;
  logic we_dm_q, we_dm_d;
  logic we_rf_q, we_rf_d;
  logic avanca_q, avanca_d;
  logic erro_q, erro_d;

  // Upper instruction bits belong to the datapath, not to sequencing.
  logic unused_ir;
  assign unused_ir = ^doutIR[31:7];

  decodifica_opcode u_decodifica_opcode (
    .opcode_i (doutIR[6:0]),
    .classe_o (classe_dec),
    .ilegal_o (ilegal_dec)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    classe_d = classe_q;
    unique case (state_q)
      StFetch: if (habilita) state_d = StDecode;
      StDecode: begin
        // Class is captured here so later states do not depend on IR staying stable.
        classe_d = classe_dec;
        state_d  = ilegal_dec ? StTrap : StExec;
      end
      StExec: begin
        case (classe_q)
          ClsLoad, ClsStore: begin
            state_d = StMem;
            cnt_d   = CntCarga;
          end
          ClsAlu:    state_d = StWb;
          ClsBranch: state_d = StFetch;
          default:   state_d = StTrap;
        endcase
      end
      StMem: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = (classe_q == ClsStore) ? StFetch : StWb;
        end
      end
      StWb:    state_d = StFetch;
      StTrap:  state_d = StTrap;
      default: state_d = StFetch;
    endcase
  end

  // Moore outputs decoded from the next state and registered alongside it.
  always_comb begin
    atualiza_d = (state_q == StFetch) && (state_d == StDecode);
    avanca_d   = (state_q != StFetch) && (state_d == StFetch);
    we_rf_d    = (state_d == StWb);
    // Store write lands only in the final MEM cycle.
    we_dm_d    = (state_d == StMem) && (cnt_d == 4'd0) && (classe_q == ClsStore);
    erro_d     = (state_d == StTrap);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StFetch;
      cnt_q      <= 4'd0;
      classe_q   <= ClsAlu;
      atualiza_q <= 1'b0;
      we_dm_q    <= 1'b0;
      we_rf_q    <= 1'b0;
      avanca_q   <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      classe_q   <= classe_d;
      atualiza_q <= atualiza_d;
      we_dm_q    <= we_dm_d;
      we_rf_q    <= we_rf_d;
      avanca_q   <= avanca_d;
      erro_q     <= erro_d;
    end
  end

  assign atualiza_pc = atualiza_q;
  assign WeDM        = we_dm_q;
  assign WeRF        = we_rf_q;
  assign avanca_pc   = avanca_q;
  assign estado      = state_q;
  assign erro        = erro_q;

`ifdef MEMORIA_CONTROLE_INSTRET_EN
  logic [W_CONT-1:0] instret_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      instret_q <= '0;
    end else if (avanca_d) begin
      instret_q <= instret_q + W_CONT'(1);
    end
  end

  assign instret = instret_q;
`else
  localparam int unsigned UnusedWCont = W_CONT;
`endif

endmodule

// File: tb/tb_memoria_controle.sv
module tb_memoria_controle;

  localparam int unsigned WC = 4;
  localparam int ND = 3;

  typedef struct packed {
    logic [2:0] st;
    logic       at;
    logic       wd;
    logic       wr;
    logic       av;
    logic       er;
  } obs_t;

  typedef struct {
    logic        r;
    logic        h;
    logic [31:0] ir;
    obs_t        e;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_r;
  logic        hab_r [ND];
  logic [31:0] ir_r  [ND];

  logic          at_w [ND];
  logic          wd_w [ND];
  logic          wr_w [ND];
  logic          av_w [ND];
  logic          er_w [ND];
  logic [2:0]    st_w [ND];
  logic [WC-1:0] cnt_w [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    memoria_controle #(
      .LAT_DM (g == 0 ? 1 : (g == 1 ? 3 : 4)),
      .W_CONT (WC)
    ) u_dut (
      .clk         (clk),
      .rst         (rst_r),
      .habilita    (hab_r[g]),
      .doutIR      (ir_r[g]),
      .atualiza_pc (at_w[g]),
      .WeDM        (wd_w[g]),
      .WeRF        (wr_w[g]),
      .avanca_pc   (av_w[g]),
      .estado      (st_w[g]),
      .erro        (er_w[g])
`ifdef MEMORIA_CONTROLE_INSTRET_EN
      ,
      .instret     (cnt_w[g])
`endif
    );
`ifndef MEMORIA_CONTROLE_INSTRET_EN
    assign cnt_w[g] = '0;
`endif
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: a per-DUT queue of the observable cycles still owed by
  // the instruction in flight, expanded from the latency rules.
  obs_t          mq [ND][$];
  bit            trap_m [ND];
  logic [WC-1:0] icnt_m [ND];
  obs_t          exp_m [ND];
  vec_t          tbl [$];

  localparam logic [31:0] IrAdd = 32'h002081B3;
  localparam logic [31:0] IrSd  = 32'h00113423;
  localparam logic [31:0] IrLd  = 32'h0000B183;
  localparam logic [31:0] IrBeq = 32'h00000063;

  function automatic int lat_of(int k);
    return k == 0 ? 1 : (k == 1 ? 3 : 4);
  endfunction

  function automatic obs_t mk(logic [2:0] st, logic at, logic wd, logic wr, logic av, logic er);
    obs_t o;
    o = {st, at, wd, wr, av, er};
    return o;
  endfunction

  task automatic push_instr(int k, logic [31:0] ir);
    int lat;
    lat = lat_of(k);
    mq[k].push_back(mk(3'd1, 1, 0, 0, 0, 0));
    case (ir[6:0])
      7'b0110011, 7'b0010011: begin
        mq[k].push_back(mk(3'd2, 0, 0, 0, 0, 0));
        mq[k].push_back(mk(3'd4, 0, 0, 1, 0, 0));
        mq[k].push_back(mk(3'd0, 0, 0, 0, 1, 0));
      end
      7'b0000011: begin
        mq[k].push_back(mk(3'd2, 0, 0, 0, 0, 0));
        for (int i = 0; i < lat; i++) mq[k].push_back(mk(3'd3, 0, 0, 0, 0, 0));
        mq[k].push_back(mk(3'd4, 0, 0, 1, 0, 0));
        mq[k].push_back(mk(3'd0, 0, 0, 0, 1, 0));
      end
      7'b0100011: begin
        mq[k].push_back(mk(3'd2, 0, 0, 0, 0, 0));
        for (int i = 0; i < lat; i++) mq[k].push_back(mk(3'd3, 0, (i == lat - 1), 0, 0, 0));
        mq[k].push_back(mk(3'd0, 0, 0, 0, 1, 0));
      end
      7'b1100011: begin
        mq[k].push_back(mk(3'd2, 0, 0, 0, 0, 0));
        mq[k].push_back(mk(3'd0, 0, 0, 0, 1, 0));
      end
      default: mq[k].push_back(mk(3'd7, 0, 0, 0, 0, 1));
    endcase
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc %0d got %0h want %0h", name, cyc, got, want);
    end
  endtask

  function automatic obs_t obs_of(int k);
    return mk(st_w[k], at_w[k], wd_w[k], wr_w[k], av_w[k], er_w[k]);
  endfunction

  // One clock: advance the model on the edge, compare every DUT 1ns later.
  task automatic step();
    @(posedge clk);
    for (int k = 0; k < ND; k++) begin
      if (rst_r) begin
        mq[k].delete();
        trap_m[k] = 1'b0;
        icnt_m[k] = '0;
        exp_m[k]  = '0;
      end else if (trap_m[k]) begin
        exp_m[k] = mk(3'd7, 0, 0, 0, 0, 1);
      end else begin
        if (mq[k].size() == 0 && hab_r[k]) push_instr(k, ir_r[k]);
        if (mq[k].size() != 0) exp_m[k] = mq[k].pop_front();
        else exp_m[k] = '0;
        if (exp_m[k].st == 3'd7) trap_m[k] = 1'b1;
        if (exp_m[k].av) icnt_m[k] = icnt_m[k] + 1'b1;
      end
    end
    #1;
    cyc++;
    for (int k = 0; k < ND; k++) begin
      chk($sformatf("model_dut%0d", k), 32'(obs_of(k)), 32'(exp_m[k]));
`ifdef MEMORIA_CONTROLE_INSTRET_EN
      chk($sformatf("instret_model_dut%0d", k), 32'(cnt_w[k]), 32'(icnt_m[k]));
`endif
    end
  endtask

  task automatic drive_all(logic h, logic [31:0] ir);
    for (int k = 0; k < ND; k++) begin
      hab_r[k] = h;
      ir_r[k]  = ir;
    end
  endtask

  task automatic idle(int n);
    drive_all(1'b0, 32'h0);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic add_row(logic r, logic h, logic [31:0] ir, obs_t e);
    vec_t v;
    v.r = r; v.h = h; v.ir = ir; v.e = e;
    tbl.push_back(v);
  endtask

  logic [17:0] st_tr;
  logic [5:0]  wd_tr, wr_tr, av_tr;
  bit          ok;
  logic [31:0] rnd;
  logic [6:0]  ops [6];

  initial begin
    rst_r = 1'b1;
    drive_all(1'b0, 32'h0);

    // Table: reset, then add and beq through the full cycle.
    add_row(1, 0, 32'h0, mk(3'd0, 0, 0, 0, 0, 0));
    add_row(1, 0, 32'h0, mk(3'd0, 0, 0, 0, 0, 0));
    add_row(0, 1, IrAdd, mk(3'd1, 1, 0, 0, 0, 0));
    add_row(0, 0, IrAdd, mk(3'd2, 0, 0, 0, 0, 0));
    add_row(0, 0, IrAdd, mk(3'd4, 0, 0, 1, 0, 0));
    add_row(0, 0, IrAdd, mk(3'd0, 0, 0, 0, 1, 0));
    add_row(0, 0, IrAdd, mk(3'd0, 0, 0, 0, 0, 0));
    add_row(0, 1, IrBeq, mk(3'd1, 1, 0, 0, 0, 0));
    add_row(0, 0, IrBeq, mk(3'd2, 0, 0, 0, 0, 0));
    add_row(0, 0, IrBeq, mk(3'd0, 0, 0, 0, 1, 0));
    add_row(0, 0, IrBeq, mk(3'd0, 0, 0, 0, 0, 0));
    foreach (tbl[i]) begin
      rst_r = tbl[i].r;
      drive_all(tbl[i].h, tbl[i].ir);
      step();
      for (int k = 0; k < ND; k++)
        chk($sformatf("table_row%0d_dut%0d", i, k), 32'(obs_of(k)), 32'(tbl[i].e));
    end

    // sd with LAT_DM=3: MEM for 3 cycles, WeDM only in the last, 6 cycles total.
    st_tr = '0; wd_tr = '0; wr_tr = '0; av_tr = '0;
    drive_all(1'b1, IrSd);
    for (int i = 0; i < 6; i++) begin
      step();
      for (int k = 0; k < ND; k++) hab_r[k] = 1'b0;
      st_tr = {st_tr[14:0], st_w[1]};
      wd_tr = {wd_tr[4:0], wd_w[1]};
      wr_tr = {wr_tr[4:0], wr_w[1]};
      av_tr = {av_tr[4:0], av_w[1]};
    end
    chk("sd_states", 32'(st_tr), 32'(18'o123330));
    chk("sd_wedm", 32'(wd_tr), 32'(6'b000010));
    chk("sd_werf", 32'(wr_tr), 32'(6'b000000));
    chk("sd_avanca", 32'(av_tr), 32'(6'b000001));
    idle(3);

    // ld with LAT_DM=1: 0,1,2,3,4 then FETCH, 5 cycles.
    st_tr = '0; wr_tr = '0;
    drive_all(1'b1, IrLd);
    for (int i = 0; i < 5; i++) begin
      step();
      for (int k = 0; k < ND; k++) hab_r[k] = 1'b0;
      st_tr = {st_tr[14:0], st_w[0]};
      wr_tr = {wr_tr[4:0], wr_w[0]};
    end
    chk("ld_states", 32'(st_tr[14:0]), 32'(15'o12340));
    chk("ld_werf", 32'(wr_tr[4:0]), 32'(5'b00010));
    idle(4);

    // Illegal opcode: TRAP is sticky with habilita high, rst recovers.
    drive_all(1'b1, 32'hFFFFFFFF);
    step();
    step();
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      for (int k = 0; k < ND; k++) if (st_w[k] !== 3'd7 || er_w[k] !== 1'b1) ok = 1'b0;
    end
    chk("trap_stuck", 32'(ok), 32'd1);
    rst_r = 1'b1;
    step();
    rst_r = 1'b0;
    for (int k = 0; k < ND; k++) chk($sformatf("trap_rst_dut%0d", k), 32'(obs_of(k)), 32'd0);

    // Store on LAT_DM=4, reset in the second MEM cycle: WeDM must never fire.
    wd_tr = '0;
    drive_all(1'b1, IrSd);
    for (int i = 0; i < 4; i++) begin
      step();
      for (int k = 0; k < ND; k++) hab_r[k] = 1'b0;
      wd_tr = {wd_tr[4:0], wd_w[2]};
    end
    chk("rstmem_in_mem", 32'(st_w[2]), 32'd3);
    rst_r = 1'b1;
    step();
    rst_r = 1'b0;
    wd_tr = {wd_tr[4:0], wd_w[2]};
    chk("rstmem_outputs", 32'(obs_of(2)), 32'd0);
    chk("rstmem_no_wedm", 32'(wd_tr), 32'd0);

`ifdef MEMORIA_CONTROLE_INSTRET_EN
    // 17 back-to-back adds wrap a 4-bit counter to 1; idle FETCH freezes it.
    drive_all(1'b1, IrAdd);
    for (int i = 0; i < 68; i++) step();
    chk("instret_wrap", 32'(cnt_w[0]), 32'd1);
    chk("instret_wrap_fetch", 32'(st_w[0]), 32'd0);
    idle(5);
    chk("instret_frozen", 32'(cnt_w[0]), 32'd1);
    chk("instret_frozen_fetch", 32'(st_w[0]), 32'd0);
`endif

    // Randomized run against the model.
    ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
    ops[3] = 7'b0100011; ops[4] = 7'b1100011; ops[5] = 7'b0110111;
    for (int n = 0; n < 1500; n++) begin
      ok = 1'b0;
      for (int k = 0; k < ND; k++) if (trap_m[k]) ok = 1'b1;
      rst_r = ($urandom % 100 == 0) || (ok && ($urandom % 6 == 0));
      for (int k = 0; k < ND; k++) begin
        if (mq[k].size() == 0 && !trap_m[k]) begin
          rnd = $urandom;
          ir_r[k] = {rnd[31:7], ($urandom % 40 == 0) ? ops[5] : ops[$urandom % 5]};
        end
        hab_r[k] = ($urandom % 4) != 0;
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
